uart_rx: RTL

Oversampling UART receiver; the stage directly downstream of the baud rate generator. It consumes the generator's `baud_clk` as a 16x-oversample timebase and recovers 8-bit (parameterisable) LSB-first frames from the serial `rx` line. It presents each frame as a one-cycle `rx_valid` pulse with framing/parity status, for the SRAM write path.

---
 rtl/uart_rx.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: recovers LSB-first frames from rx using baud_clk
// rising edges as a SAMPLE-per-bit timebase, and reports each frame with a one-cycle rx_valid.
`timescale 1ns/1ps
module uart_rx #(
    parameter int SAMPLE    = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic                 SysClk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CW = $clog2(SAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(SAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic          ODD_PAR  = (PARITY == 2);
    localparam logic          HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BRK   = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   perr_q, perr_d;
    logic                   baud_q;
    logic                   sync1_q, sync2_q;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic                   tick;
    logic                   rx_s;

    assign tick = baud_clk & ~baud_q;
    assign rx_s = sync2_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        perr_d       = perr_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        case (state_q)
            IDLE: begin
                if (tick && !rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d = '0;
                        // A line that has returned high by mid-bit was a glitch.
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_idx_d = '0;
                            par_d     = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                        par_d     = par_q ^ rx_s;
                        cnt_d     = '0;
                        bit_idx_d = bit_idx_q + BW'(1);
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = HAS_PAR ? PAR : STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        perr_d  = par_q ^ rx_s ^ ODD_PAR;
                        cnt_d   = '0;
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        rx_data_d    = shreg_q;
                        parity_err_d = HAS_PAR & perr_q;
                        frame_err_d  = ~rx_s;
                        rx_valid_d   = 1'b1;
                        cnt_d        = '0;
                        state_d      = rx_s ? IDLE : BRK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            BRK: begin
                // Leaves on the line level alone so a held-low break yields one frame.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge SysClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            baud_q       <= 1'b0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            baud_q       <= baud_clk;
            sync1_q      <= rx;
            sync2_q      <= sync1_q;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
    assign dbg_state  = state_q;

endmodule
